// File: rtl/clk_gen_multi_pkg.sv
// rtl/clk_gen_multi_pkg.sv - shared constants and helpers for the multi-channel clock generator
// Purpose: minimum divisor, default parameter values and a select-width helper
//          used by clk_gen_multi and clk_div_channel.
// Ports:   none (package).
package clk_gen_multi_pkg;

   // Smallest legal divide ratio; written values below this are clamped up.
   localparam int MIN_DIV         = 2;

   localparam int DEF_CHANNELS    = 4;
   localparam int DEF_CNT_W       = 16;
   localparam int DEF_DEFAULT_DIV = 2;

   // Channel-select width, never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one programmable divider channel with glitch-free ratio update
// Purpose: counts clock cycles modulo the active divide ratio, producing a divided
//          clock and a one-cycle tick per period. A written ratio is held in
//          r_div_next and swapped in at terminal count or on sync.
// Ports:   i_clk     - clock (posedge)
//          i_resetn  - synchronous active-low reset
//          i_enable  - count enable
//          i_sync    - phase realign, overrides i_enable
//          i_wr      - write strobe for this channel (already address-decoded)
//          i_data    - new divide ratio
//          o_clk     - divided clock
//          o_tick    - one-cycle strobe at each wrap
//          o_pending - a written ratio awaits its apply point
module clk_div_channel
   import clk_gen_multi_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int DEFAULT_DIV = DEF_DEFAULT_DIV
)(
   input  logic             i_clk,
   input  logic             i_resetn,
   input  logic             i_enable,
   input  logic             i_sync,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_data,
   output logic             o_clk,
   output logic             o_tick,
   output logic             o_pending
);

   localparam logic [CNT_W-1:0] DEF_D = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DIV);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_div_active;
   logic [CNT_W-1:0] r_div_next;
   logic             r_pending;
   logic             r_clk;
   logic             r_tick;

   logic             w_wrap;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [CNT_W-1:0] w_data_clamped;

   assign w_wrap         = (r_cnt == r_div_active - ONE);
   assign w_cnt_inc      = r_cnt + ONE;
   assign w_data_clamped = (i_data < MIN_D) ? MIN_D : i_data;

   always_ff @(posedge i_clk) begin
      if (!i_resetn) begin
         r_cnt        <= '0;
         r_div_active <= DEF_D;
         r_div_next   <= DEF_D;
         r_pending    <= 1'b0;
         r_clk        <= 1'b0;
         r_tick       <= 1'b0;
      end else begin
         if (i_sync) begin
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
            if (r_pending) begin
               r_div_active <= r_div_next;
            end
            r_pending <= 1'b0;
         end else if (i_enable) begin
            r_tick <= w_wrap;
            if (w_wrap) begin
               // Next count is 0 and every ratio is >= 2, so the low half
               // is never empty: clk_out is 0 whichever ratio applies.
               r_cnt <= '0;
               r_clk <= 1'b0;
               if (r_pending) begin
                  r_div_active <= r_div_next;
                  r_pending    <= 1'b0;
               end
            end else begin
               r_cnt <= w_cnt_inc;
               r_clk <= (w_cnt_inc >= (r_div_active >> 1));
            end
         end else begin
            r_tick <= 1'b0;
         end

         // Placed last so a write coinciding with an apply point stays pending.
         if (i_wr) begin
            r_div_next <= w_data_clamped;
            r_pending  <= 1'b1;
         end
      end
   end

   assign o_clk     = r_clk;
   assign o_tick    = r_tick;
   assign o_pending = r_pending;

endmodule

// File: rtl/clk_gen_multi.sv
// rtl/clk_gen_multi.sv - multi-channel programmable clock divider with common phase sync
// Purpose: decodes divisor writes to one of CHANNELS divider channels and fans the
//          shared controls out to every channel.
// Ports:   clk_in      - clock (posedge)
//          reset       - synchronous active-low reset
//          enable      - global count enable
//          sync        - realign all channels to phase 0
//          div_wr      - divisor write strobe
//          div_sel     - target channel; values >= CHANNELS are ignored
//          div_data    - new divide ratio (0 and 1 clamp to 2)
//          clk_out     - divided clocks, one per channel
//          tick        - one-cycle period strobes, one per channel
//          div_pending - per channel, a written ratio awaits its apply point
module clk_gen_multi
   import clk_gen_multi_pkg::*;
#(
   parameter  int CHANNELS    = DEF_CHANNELS,
   parameter  int CNT_W       = DEF_CNT_W,
   parameter  int DEFAULT_DIV = DEF_DEFAULT_DIV,
   localparam int SEL_W       = sel_width(CHANNELS)
)(
   input  logic                clk_in,
   input  logic                reset,
   input  logic                enable,
   input  logic                sync,
   input  logic                div_wr,
   input  logic [SEL_W-1:0]    div_sel,
   input  logic [CNT_W-1:0]    div_data,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] div_pending
);

   logic [CHANNELS-1:0] w_wr_en;

   // One-hot decode; a select beyond the last channel matches nothing.
   always_comb begin
      w_wr_en = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_wr_en[i] = div_wr && (div_sel == SEL_W'(i));
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      clk_div_channel #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .i_clk     (clk_in),
         .i_resetn  (reset),
         .i_enable  (enable),
         .i_sync    (sync),
         .i_wr      (w_wr_en[g]),
         .i_data    (div_data),
         .o_clk     (clk_out[g]),
         .o_tick    (tick[g]),
         .o_pending (div_pending[g])
      );
   end

endmodule

// File: tb/tb_clk_gen_multi.sv
// tb/tb_clk_gen_multi.sv - self-checking bench for clk_gen_multi
module tb_clk_gen_multi;

   localparam int CH  = 4;
   localparam int CHB = 3;

   logic        clk_in = 1'b0;
   logic        reset;
   logic        enable;
   logic        sync;
   logic        div_wr;
   logic [1:0]  div_sel;
   logic [15:0] div_data;
   logic [3:0]  clk_out;
   logic [3:0]  tick;
   logic [3:0]  div_pending;

   logic        b_wr;
   logic [1:0]  b_sel;
   logic [7:0]  b_data;
   logic [2:0]  b_clk_out;
   logic [2:0]  b_tick;
   logic [2:0]  b_pending;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk_in = ~clk_in;

   clk_gen_multi #(.CHANNELS(CH), .CNT_W(16), .DEFAULT_DIV(2)) dut (
      .clk_in      (clk_in),
      .reset       (reset),
      .enable      (enable),
      .sync        (sync),
      .div_wr      (div_wr),
      .div_sel     (div_sel),
      .div_data    (div_data),
      .clk_out     (clk_out),
      .tick        (tick),
      .div_pending (div_pending)
   );

   // Non-power-of-two instance: select value 3 addresses no channel.
   clk_gen_multi #(.CHANNELS(CHB), .CNT_W(8), .DEFAULT_DIV(3)) dut_b (
      .clk_in      (clk_in),
      .reset       (reset),
      .enable      (1'b1),
      .sync        (1'b0),
      .div_wr      (b_wr),
      .div_sel     (b_sel),
      .div_data    (b_data),
      .clk_out     (b_clk_out),
      .tick        (b_tick),
      .div_pending (b_pending)
   );

   // Reference model: each channel is a position within its current period
   // of length m_d; the divided clock is low for the first floor(D/2) positions.
   int m_phase [CH];
   int m_d     [CH];
   int m_nxt   [CH];
   bit m_pend  [CH];
   bit m_clk   [CH];
   bit m_tick  [CH];
   int nb;   // enabled cycles of dut_b since reset

   always @(posedge clk_in) begin
      if (!reset) begin
         for (int c = 0; c < CH; c++) begin
            m_phase[c] = 0; m_d[c] = 2; m_nxt[c] = 2;
            m_pend[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
         end
         nb = 0;
      end else begin
         nb = nb + 1;
         for (int c = 0; c < CH; c++) begin
            if (sync) begin
               m_phase[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
               if (m_pend[c]) m_d[c] = m_nxt[c];
               m_pend[c] = 0;
            end else if (enable) begin
               if (m_phase[c] == m_d[c] - 1) begin
                  m_tick[c] = 1;
                  if (m_pend[c]) begin
                     m_d[c] = m_nxt[c];
                     m_pend[c] = 0;
                  end
                  m_phase[c] = 0;
               end else begin
                  m_tick[c] = 0;
                  m_phase[c] = m_phase[c] + 1;
               end
               m_clk[c] = (m_phase[c] >= m_d[c] / 2);
            end else begin
               m_tick[c] = 0;
            end
         end
         if (div_wr && int'(div_sel) < CH) begin
            m_nxt[int'(div_sel)]  = (int'(div_data) < 2) ? 2 : int'(div_data);
            m_pend[int'(div_sel)] = 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [3:0] e_clk, e_tick, e_pend;
      logic [2:0] eb_clk, eb_tick;
      for (int c = 0; c < CH; c++) begin
         e_clk[c]  = m_clk[c];
         e_tick[c] = m_tick[c];
         e_pend[c] = m_pend[c];
      end
      eb_clk  = (nb % 3 != 0) ? 3'b111 : 3'b000;
      eb_tick = (nb > 0 && nb % 3 == 0) ? 3'b111 : 3'b000;
      chk("clk_out", 32'(clk_out), 32'(e_clk));
      chk("tick", 32'(tick), 32'(e_tick));
      chk("div_pending", 32'(div_pending), 32'(e_pend));
      chk("b_clk_out", 32'(b_clk_out), 32'(eb_clk));
      chk("b_tick", 32'(b_tick), 32'(eb_tick));
      chk("b_pending", 32'(b_pending), 32'h0);
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         check_all();
      end
   endtask

   task automatic wr(input int sel, input int data);
      div_wr   = 1'b1;
      div_sel  = 2'(sel);
      div_data = 16'(data);
      cyc(1);
      div_wr   = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; sync = 1'b0;
      div_wr = 1'b0; div_sel = '0; div_data = '0;
      b_wr = 1'b0; b_sel = '0; b_data = '0;

      // Reset and defaults
      cyc(2);
      chk("reset_clk_out", 32'(clk_out), 32'h0);
      reset = 1'b1; enable = 1'b1;
      cyc(6);

      // Reprogram ch1 to 5 mid-period
      wr(1, 5);
      cyc(20);

      // Clamp: 0 and 1 both become 2
      wr(2, 0);
      wr(2, 1);
      cyc(8);

      // Out-of-range select on the 3-channel instance
      b_wr = 1'b1; b_sel = 2'd3; b_data = 8'd7;
      cyc(1);
      b_wr = 1'b0;
      cyc(6);

      // Enable gating in the middle of a D=6 period
      wr(0, 6);
      cyc(9);
      enable = 1'b0;
      cyc(7);
      enable = 1'b1;
      cyc(12);

      // Sync alignment with a pending ch3 divisor
      wr(0, 4);
      wr(2, 6);
      cyc(7);
      wr(3, 3);
      sync = 1'b1;
      cyc(1);
      chk("sync_clk_out", 32'(clk_out), 32'h0);
      sync = 1'b0;
      cyc(25);

      // Reset mid-operation
      wr(1, 9);
      cyc(12);
      wr(3, 7);
      reset = 1'b0;
      cyc(1);
      chk("midreset_pending", 32'(div_pending), 32'h0);
      reset = 1'b1;
      cyc(6);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 199) != 0);
         enable   = ($urandom_range(0, 7) != 0);
         sync     = ($urandom_range(0, 39) == 0);
         div_wr   = ($urandom_range(0, 5) == 0);
         div_sel  = 2'($urandom_range(0, 3));
         div_data = 16'($urandom_range(0, 12));
         b_wr     = ($urandom_range(0, 4) == 0);
         b_sel    = 2'd3;
         b_data   = 8'($urandom_range(0, 255));
         cyc(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
